stream_in_frame_rx: RTL and testbench

- Next-generation AXI-Stream input stage in front of Up-Sampling; supersedes plain bypass gating.
- Tracks the frame by column and row counters, with optional start-of-frame sync on tuser.
- Strips bus padding down to PIXEL_WIDTH and tags each pixel with sof/eol sideband.
- Decouples the ready path with a 2-entry buffer, so s_axis_tready has no combinational dependence on upsp_ac_rready.

---
 rtl/stream_in_pkg.sv | 19 +
 rtl/stream_in_frame_rx_if.sv | 31 +++
 rtl/axis_skid_buf.sv | 54 +++++
 rtl/stream_in_frame_rx.sv | 153 +++++++++++++++
 tb/tb_stream_in_frame_rx.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_in_pkg.sv
// Shared types and constants for the AXIS frame receiver.
// Purpose : FSM state encoding and the width of a buffered pixel entry.
// Latency : n/a (package). Backpressure: n/a.
package stream_in_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    RECV     = 2'd2
  } state_t;

  // Each buffer entry carries the pixel plus the two sideband bits {sof, eol}.
  localparam int SIDEBAND_BITS = 2;

  function automatic int entry_width(input int pixel_width);
    return pixel_width + SIDEBAND_BITS;
  endfunction

endpackage

// File: rtl/stream_in_frame_rx_if.sv
// Bundles the AXIS input channel and the pixel output channel of the receiver.
// Ports   : s_axis_* (tvalid/tready/tdata/tlast/user), ac_upsp_* / upsp_ac_rready.
// Modports: slave = the receiver, master = the surrounding environment.
interface stream_in_frame_rx_if #(
  parameter int AXISIN_DATA_WIDTH = 32,
  parameter int PIXEL_WIDTH       = 24
);

  logic                         s_axis_tvalid;
  logic                         s_axis_tready;
  logic [AXISIN_DATA_WIDTH-1:0] s_axis_tdata;
  logic                         s_axis_tlast;
  logic                         s_axis_user;

  logic                         ac_upsp_rvalid;
  logic                         upsp_ac_rready;
  logic [PIXEL_WIDTH-1:0]       ac_upsp_rdata;
  logic                         ac_upsp_sof;
  logic                         ac_upsp_eol;

  modport slave (
    input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, s_axis_user, upsp_ac_rready,
    output s_axis_tready, ac_upsp_rvalid, ac_upsp_rdata, ac_upsp_sof, ac_upsp_eol
  );

  modport master (
    output s_axis_tvalid, s_axis_tdata, s_axis_tlast, s_axis_user, upsp_ac_rready,
    input  s_axis_tready, ac_upsp_rvalid, ac_upsp_rdata, ac_upsp_sof, ac_upsp_eol
  );

endinterface

// File: rtl/axis_skid_buf.sv
// Purpose : 2-entry FIFO that decouples the AXIS ready path from the consumer.
// Latency : 1 cycle push -> head visible; full throughput with push+pop each cycle.
// Backpressure: full asserts at 2 entries; a push while full is only taken with a pop.
// Ports   : clk, rst_n, push/push_dat, pop, flush, head_dat, full, count.
module axis_skid_buf #(
  parameter int DATA_WIDTH = 26
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_dat,
  input  logic                  pop,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] head_dat,
  output logic                  full,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full     = (count == 2'd2);
  assign do_pop   = pop && (count != 2'd0);
  assign do_push  = push && (!full || do_pop);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/stream_in_frame_rx.sv
// Purpose : AXIS frame receiver; tracks col/row, optional tuser SOF sync, strips
//           padding to PIXEL_WIDTH and tags pixels with sof/eol. Optional stats via
//           macro STREAM_IN_FRAME_STAT_EN (err_early_eol_cnt, err_missing_eol_cnt, frame_cnt).
// Latency : 1 cycle AXIS handshake -> ac_upsp_rvalid. Backpressure: s_axis_tready comes
//           from registered state and buffer count only (never from upsp_ac_rready).
// Ports   : s_axis_aclk, s_axis_arstn, UPSTART, UPEND, bus (slave), frame_busy, frame_err.
import stream_in_pkg::*;

module stream_in_frame_rx #(
  parameter int AXISIN_DATA_WIDTH = 32,
  parameter int PIXEL_WIDTH       = 24,
  parameter int SRC_IMG_WIDTH     = 3840,
  parameter int SRC_IMG_HEIGHT    = 2160,
  parameter int SOF_SYNC          = 1
) (
  input  logic                     s_axis_aclk,
  input  logic                     s_axis_arstn,
  input  logic                     UPSTART,
  input  logic                     UPEND,
  stream_in_frame_rx_if.slave      bus,
  output logic                     frame_busy,
  output logic                     frame_err
`ifdef STREAM_IN_FRAME_STAT_EN
  ,
  output logic [15:0]              err_early_eol_cnt,
  output logic [15:0]              err_missing_eol_cnt,
  output logic [15:0]              frame_cnt
`endif
);

  localparam int EW = entry_width(PIXEL_WIDTH);
  localparam int CW = (SRC_IMG_WIDTH  > 1) ? $clog2(SRC_IMG_WIDTH)  : 1;
  localparam int RW = (SRC_IMG_HEIGHT > 1) ? $clog2(SRC_IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(SRC_IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(SRC_IMG_HEIGHT - 1);

  state_t          state;
  logic [CW-1:0]   col;
  logic [RW-1:0]   row;

  logic            hs;
  logic            beat;
  logic            at_origin;
  logic            at_eol;
  logic            at_end;
  logic            early_eol;
  logic            missing_eol;
  logic            bad_sof;
  logic [EW-1:0]   push_dat;
  logic [EW-1:0]   head_dat;
  logic            buf_full;
  logic [1:0]      buf_cnt;

  // Padding above PIXEL_WIDTH is intentionally discarded.
  logic            unused_tdata;
  assign unused_tdata = ^{1'b0, bus.s_axis_tdata};

  // In WAIT_SOF junk beats must be drained regardless of buffer space.
  assign bus.s_axis_tready = (state == WAIT_SOF) || ((state == RECV) && !buf_full);
  assign hs = bus.s_axis_tvalid && bus.s_axis_tready;

  assign at_origin = (col == '0) && (row == '0);
  assign at_eol    = (col == COL_LAST);
  assign at_end    = at_eol && (row == ROW_LAST);

  // A beat that becomes a pixel; UPEND wins over a same-cycle handshake.
  assign beat = hs && !UPEND &&
                ((state == RECV) || ((state == WAIT_SOF) && bus.s_axis_user));

  assign early_eol   = beat && bus.s_axis_tlast && !at_eol;
  assign missing_eol = beat && !bus.s_axis_tlast && at_eol;
  assign bad_sof     = beat && (state == RECV) && bus.s_axis_user && !at_origin;

  assign push_dat = {bus.s_axis_tdata[PIXEL_WIDTH-1:0], at_origin, at_eol};

  always_ff @(posedge s_axis_aclk or negedge s_axis_arstn) begin
    if (!s_axis_arstn) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      frame_err <= 1'b0;
    end else if (UPEND) begin
      state <= IDLE;
      col   <= '0;
      row   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (UPSTART) begin
            state     <= (SOF_SYNC != 0) ? WAIT_SOF : RECV;
            col       <= '0;
            row       <= '0;
            frame_err <= 1'b0;
          end
        end
        default: ;
      endcase

      // Row advance is purely counter-driven; tlast only feeds the error checks.
      if (beat) begin
        if (at_eol) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        if (at_end)                 state <= IDLE;
        else if (state == WAIT_SOF) state <= RECV;
        if (early_eol || missing_eol || bad_sof) frame_err <= 1'b1;
      end
    end
  end

  assign frame_busy = (state != IDLE);

  axis_skid_buf #(
    .DATA_WIDTH (EW)
  ) u_buf (
    .clk      (s_axis_aclk),
    .rst_n    (s_axis_arstn),
    .push     (beat),
    .push_dat (push_dat),
    .pop      (bus.upsp_ac_rready),
    .flush    (UPEND),
    .head_dat (head_dat),
    .full     (buf_full),
    .count    (buf_cnt)
  );

  assign bus.ac_upsp_rvalid = (buf_cnt != 2'd0);
  assign bus.ac_upsp_rdata  = head_dat[EW-1:2];
  assign bus.ac_upsp_sof    = head_dat[1];
  assign bus.ac_upsp_eol    = head_dat[0];

`ifdef STREAM_IN_FRAME_STAT_EN
  // Saturating counters; only reset clears them, UPSTART does not.
  always_ff @(posedge s_axis_aclk or negedge s_axis_arstn) begin
    if (!s_axis_arstn) begin
      err_early_eol_cnt   <= 16'd0;
      err_missing_eol_cnt <= 16'd0;
      frame_cnt           <= 16'd0;
    end else begin
      if (early_eol && (err_early_eol_cnt != 16'hFFFF))
        err_early_eol_cnt <= err_early_eol_cnt + 16'd1;
      if (missing_eol && (err_missing_eol_cnt != 16'hFFFF))
        err_missing_eol_cnt <= err_missing_eol_cnt + 16'd1;
      if (beat && at_end && (frame_cnt != 16'hFFFF))
        frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stream_in_frame_rx.sv
// Bench for stream_in_frame_rx with a 4x2 frame, SOF sync on, 24-bit pixels in 32-bit beats.
// A cycle table covers junk-before-SOF plus a clean frame; hand sequences cover
// backpressure, tlast errors, UPEND abort and asynchronous reset mid-frame.
module tb_stream_in_frame_rx;

  localparam int DW = 32;
  localparam int PW = 24;
  localparam int W  = 4;
  localparam int H  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic arstn;
  logic upstart;
  logic upend;
  logic busy;
  logic err;

  stream_in_frame_rx_if #(.AXISIN_DATA_WIDTH(DW), .PIXEL_WIDTH(PW)) bus ();

`ifdef STREAM_IN_FRAME_STAT_EN
  logic [15:0] st_early;
  logic [15:0] st_missing;
  logic [15:0] st_frames;
`endif

  stream_in_frame_rx #(
    .AXISIN_DATA_WIDTH (DW),
    .PIXEL_WIDTH       (PW),
    .SRC_IMG_WIDTH     (W),
    .SRC_IMG_HEIGHT    (H),
    .SOF_SYNC          (1)
  ) dut (
    .s_axis_aclk         (clk),
    .s_axis_arstn        (arstn),
    .UPSTART             (upstart),
    .UPEND               (upend),
    .bus                 (bus),
    .frame_busy          (busy),
    .frame_err           (err)
`ifdef STREAM_IN_FRAME_STAT_EN
    ,
    .err_early_eol_cnt   (st_early),
    .err_missing_eol_cnt (st_missing),
    .frame_cnt           (st_frames)
`endif
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Every pixel accepted downstream: {rdata, sof, eol}.
  logic [25:0] got_q [$];
  always @(negedge clk)
    if (bus.ac_upsp_rvalid && bus.upsp_ac_rready)
      got_q.push_back({bus.ac_upsp_rdata, bus.ac_upsp_sof, bus.ac_upsp_eol});

  typedef struct packed {
    logic        upstart;
    logic        tvalid;
    logic [31:0] tdata;
    logic        tlast;
    logic        tuser;
    logic        x_tready;
    logic        x_rvalid;
    logic [23:0] x_rdata;
    logic        x_sof;
    logic        x_eol;
    logic        x_busy;
    logic        x_err;
  } vec_t;

  vec_t        tbl [13];
  logic [26:0] hold;
  int          base;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_tready"}, 32'(bus.s_axis_tready), 0);
    chk({tag, "_rvalid"}, 32'(bus.ac_upsp_rvalid), 0);
    chk({tag, "_rdata"},  32'(bus.ac_upsp_rdata), 0);
    chk({tag, "_sof"},    32'(bus.ac_upsp_sof), 0);
    chk({tag, "_eol"},    32'(bus.ac_upsp_eol), 0);
    chk({tag, "_busy"},   32'(busy), 0);
    chk({tag, "_err"},    32'(err), 0);
  endtask

  task automatic pulse_start();
    upstart = 1'b1;
    @(posedge clk); #1;
    upstart = 1'b0;
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic send_beat(input int k, input logic last, input logic user);
    int n;
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = 32'hAA000000 + 32'(k);
    bus.s_axis_tlast  = last;
    bus.s_axis_user   = user;
    n = 0;
    @(negedge clk);
    while (!bus.s_axis_tready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.s_axis_tready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL beat_timeout: beat %0d tready 0 expected 1", k);
    end
    @(posedge clk); #1;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    bus.s_axis_user   = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] last_m, input logic [7:0] user_m);
    for (int k = 0; k < 8; k++) send_beat(k, last_m[k], user_m[k]);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.ac_upsp_rvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drained"}, 32'(bus.ac_upsp_rvalid), 0);
    @(posedge clk); #1;
  endtask

  // Expected frame: pixel k = k, sof on pixel 0, eol from counter position.
  task automatic check_frame(input string tag, input int b, input logic [7:0] eol_m);
    logic [25:0] exp;
    chk({tag, "_count"}, 32'(got_q.size() - b), 8);
    for (int k = 0; k < 8; k++) begin
      exp = {24'(k), (k == 0), eol_m[k]};
      if (b + k < got_q.size())
        chk($sformatf("%s_pix%0d", tag, k), 32'(got_q[b + k]), 32'(exp));
    end
  endtask

  initial begin
    arstn              = 1'b0;
    upstart            = 1'b0;
    upend              = 1'b0;
    bus.s_axis_tvalid  = 1'b0;
    bus.s_axis_tdata   = '0;
    bus.s_axis_tlast   = 1'b0;
    bus.s_axis_user    = 1'b0;
    bus.upsp_ac_rready = 1'b1;

    // Table: 3 junk beats before SOF, then a clean 4x2 frame, then idle.
    for (int i = 0; i < 13; i++) tbl[i] = '0;
    tbl[0].upstart = 1'b1;
    tbl[0].x_busy  = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tbl[i].tvalid   = 1'b1;
      tbl[i].tdata    = 32'h55000000 + 32'(i);
      tbl[i].x_tready = 1'b1;
      tbl[i].x_busy   = 1'b1;
    end
    for (int k = 0; k < 8; k++) begin
      tbl[4 + k].tvalid   = 1'b1;
      tbl[4 + k].tdata    = 32'hAA000000 + 32'(k);
      tbl[4 + k].tuser    = (k == 0);
      tbl[4 + k].tlast    = (k == 3) || (k == 7);
      tbl[4 + k].x_tready = 1'b1;
      tbl[4 + k].x_rvalid = 1'b1;
      tbl[4 + k].x_rdata  = 24'(k);
      tbl[4 + k].x_sof    = (k == 0);
      tbl[4 + k].x_eol    = (k == 3) || (k == 7);
      tbl[4 + k].x_busy   = (k != 7);
    end

    #1 chk_reset("rst");
    repeat (3) @(posedge clk);
    #2 arstn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      upstart           = tbl[i].upstart;
      bus.s_axis_tvalid = tbl[i].tvalid;
      bus.s_axis_tdata  = tbl[i].tdata;
      bus.s_axis_tlast  = tbl[i].tlast;
      bus.s_axis_user   = tbl[i].tuser;
      @(negedge clk);
      chk($sformatf("v%0d_tready", i), 32'(bus.s_axis_tready), 32'(tbl[i].x_tready));
      @(posedge clk); #1;
      chk($sformatf("v%0d_rvalid", i), 32'(bus.ac_upsp_rvalid), 32'(tbl[i].x_rvalid));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].x_busy));
      chk($sformatf("v%0d_err", i), 32'(err), 32'(tbl[i].x_err));
      if (tbl[i].x_rvalid)
        chk($sformatf("v%0d_pix", i),
            32'({bus.ac_upsp_rdata, bus.ac_upsp_sof, bus.ac_upsp_eol}),
            32'({tbl[i].x_rdata, tbl[i].x_sof, tbl[i].x_eol}));
    end
    upstart           = 1'b0;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    bus.s_axis_user   = 1'b0;

    // Backpressure: rready low 5 cycles mid-frame.
    base = got_q.size();
    pulse_start();
    fork
      send_frame(8'h88, 8'h01);
      begin
        repeat (3) @(posedge clk);
        #1 bus.upsp_ac_rready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          if (k == 0)
            hold = {bus.ac_upsp_rvalid, bus.ac_upsp_rdata, bus.ac_upsp_sof, bus.ac_upsp_eol};
          else
            chk($sformatf("bp_hold%0d", k),
                {5'b0, bus.ac_upsp_rvalid, bus.ac_upsp_rdata, bus.ac_upsp_sof, bus.ac_upsp_eol},
                {5'b0, hold});
          if (k >= 2) chk($sformatf("bp_tready%0d", k), 32'(bus.s_axis_tready), 0);
        end
        @(posedge clk); #1;
        bus.upsp_ac_rready = 1'b1;
      end
    join
    drain("bp");
    check_frame("bp", base, 8'h88);
    chk("bp_err", 32'(err), 0);

    // Early tlast on beat 1: error, but eol still follows the counters.
    base = got_q.size();
    pulse_start();
    send_frame(8'h8A, 8'h01);
    drain("early");
    check_frame("early", base, 8'h88);
    chk("early_err", 32'(err), 1);

    // Missing tlast at column W-1 of row 0.
    base = got_q.size();
    pulse_start();
    chk("miss_clr_err", 32'(err), 0);
    send_frame(8'h80, 8'h01);
    drain("miss");
    check_frame("miss", base, 8'h88);
    chk("miss_err", 32'(err), 1);

    // UPEND abort with 2 pixels buffered.
    pulse_start();
    chk("abort_clr_err", 32'(err), 0);
    for (int k = 0; k < 4; k++) send_beat(k, (k == 3), (k == 0));
    bus.upsp_ac_rready = 1'b0;
    send_beat(4, 1'b0, 1'b0);
    @(negedge clk);
    chk("abort_full_tready", 32'(bus.s_axis_tready), 0);
    chk("abort_full_rvalid", 32'(bus.ac_upsp_rvalid), 1);
    @(posedge clk); #1;
    upend = 1'b1;
    @(posedge clk); #1;
    upend = 1'b0;
    chk("abort_rvalid", 32'(bus.ac_upsp_rvalid), 0);
    chk("abort_tready", 32'(bus.s_axis_tready), 0);
    chk("abort_busy", 32'(busy), 0);
    bus.upsp_ac_rready = 1'b1;
    @(posedge clk); #1;
    base = got_q.size();
    pulse_start();
    send_frame(8'h88, 8'h01);
    drain("post_abort");
    check_frame("post_abort", base, 8'h88);
    chk("post_abort_err", 32'(err), 0);

    // Asynchronous reset after beat 5.
    pulse_start();
    for (int k = 0; k < 6; k++) send_beat(k, (k == 3), (k == 0));
    #2 arstn = 1'b0;
    #1 chk_reset("midrst");
    @(negedge clk);
    arstn = 1'b1;
    @(posedge clk); #1;
    base = got_q.size();
    pulse_start();
    send_frame(8'h88, 8'h01);
    drain("post_rst");
    check_frame("post_rst", base, 8'h88);
    chk("post_rst_err", 32'(err), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
